// File: rtl/ucsbece154a_imem_loader_pkg.sv
// Shared constants for the instruction loader: kind codes, RV32I opcodes, forced funct3
// values, FSM encoding and the field bundle layout used by the packer.
package ucsbece154a_imem_loader_pkg;

  typedef enum logic [2:0] {
    K_LW   = 3'd0,
    K_SW   = 3'd1,
    K_R    = 3'd2,
    K_BEQ  = 3'd3,
    K_IALU = 3'd4,
    K_JAL  = 3'd5,
    K_LUI  = 3'd6,
    K_ILL  = 3'd7
  } kind_t;

  // Opcodes match the ones the main decoder recognises.
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_VERIFY = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  typedef struct packed {
    kind_t       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
  } fields_t;

  // True when v is the sign extension of its low w bits.
  function automatic logic fits_signed(input logic [31:0] v, input int w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (i >= w && v[i] != v[w-1]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/ucsbece154a_instr_pack.sv
// Combinational field-to-word packer for the RV32I subset the core executes; flags
// bundles whose immediate cannot be encoded or whose kind is not supported.
module ucsbece154a_instr_pack
  import ucsbece154a_imem_loader_pkg::*;
(
  input  fields_t     fields,
  output logic [31:0] word,
  output logic        illegal
);

  logic [31:0] imm;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;

  assign imm = fields.imm;
  assign rd  = fields.rd;
  assign rs1 = fields.rs1;
  assign rs2 = fields.rs2;

  always_comb begin
    word    = 32'h0;
    illegal = 1'b0;
    case (fields.kind)
      K_LW: begin
        word    = {imm[11:0], rs1, F3_LW, rd, OP_LW};
        illegal = !fits_signed(imm, 12);
      end
      K_SW: begin
        word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_SW};
        illegal = !fits_signed(imm, 12);
      end
      K_R: begin
        word = {1'b0, fields.funct7b5, 5'b0, rs2, rs1, fields.funct3, rd, OP_R};
      end
      K_BEQ: begin
        // Branch offsets are in bytes; bit 0 is implied zero and never stored.
        word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BEQ};
        illegal = !fits_signed(imm, 13) || imm[0];
      end
      K_IALU: begin
        word    = {imm[11:0], rs1, fields.funct3, rd, OP_IALU};
        illegal = !fits_signed(imm, 12);
      end
      K_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        illegal = !fits_signed(imm, 21) || imm[0];
      end
      K_LUI: begin
        word    = {imm[31:12], rd, OP_LUI};
        illegal = (imm[11:0] != 12'h0);
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ucsbece154a_imem_loader.sv
// Loads packed RV32I words into instruction memory, one accepted bundle per write slot.
// Optional read-back check of every written word is enabled by UCSBECE154A_LOADER_VERIFY_EN.
module ucsbece154a_imem_loader
  import ucsbece154a_imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [2:0]               kind_i,
  input  logic [4:0]               rd_i,
  input  logic [4:0]               rs1_i,
  input  logic [4:0]               rs2_i,
  input  logic [2:0]               funct3_i,
  input  logic                     funct7b5_i,
  input  logic [31:0]              imm_i,
  input  logic                     last_i,
  output logic                     mem_we_o,
  output logic [31:0]              mem_addr_o,
  output logic [31:0]              mem_wd_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef UCSBECE154A_LOADER_VERIFY_EN
  ,
  input  logic [31:0]              mem_rd_i,
  output logic                     verr_o
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t        state;
  fields_t       fields;
  logic [31:0]   word;
  logic          illegal;
  logic          last_q;
  logic          wr_q;
  logic [CW-1:0] cnt_next;
  logic          session_end;
  logic          adv;

  assign fields = '{
    kind:     kind_t'(kind_i),
    rd:       rd_i,
    rs1:      rs1_i,
    rs2:      rs2_i,
    funct3:   funct3_i,
    funct7b5: funct7b5_i,
    imm:      imm_i
  };

  ucsbece154a_instr_pack u_pack (
    .fields  (fields),
    .word    (word),
    .illegal (illegal)
  );

  // A rejected bundle still occupies a slot but leaves address and count untouched.
  assign cnt_next    = count_o + CW'(wr_q);
  assign session_end = last_q || (cnt_next == DEPTH_C);

`ifdef UCSBECE154A_LOADER_VERIFY_EN
  assign adv = (state == S_VERIFY) || ((state == S_WRITE) && !wr_q);
`else
  assign adv = (state == S_WRITE);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready_o <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= BASE_ADDR;
      mem_wd_o   <= 32'h0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      count_o    <= '0;
      last_q     <= 1'b0;
      wr_q       <= 1'b0;
`ifdef UCSBECE154A_LOADER_VERIFY_EN
      verr_o     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state      <= S_ACCEPT;
            in_ready_o <= 1'b1;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            mem_addr_o <= BASE_ADDR;
            count_o    <= '0;
          end
        end
        S_ACCEPT: begin
          if (in_valid_i) begin
            state      <= S_WRITE;
            in_ready_o <= 1'b0;
            last_q     <= last_i;
            wr_q       <= !illegal;
            mem_we_o   <= !illegal;
            if (illegal) err_o <= 1'b1;
            else         mem_wd_o <= word;
          end
        end
        S_WRITE: begin
          mem_we_o <= 1'b0;
`ifdef UCSBECE154A_LOADER_VERIFY_EN
          if (wr_q) state <= S_VERIFY;
`endif
        end
`ifdef UCSBECE154A_LOADER_VERIFY_EN
        S_VERIFY: begin
          // Memory read is combinational, so the word written last cycle is visible now.
          if (mem_rd_i != mem_wd_o) verr_o <= 1'b1;
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (adv) begin
        if (wr_q) begin
          mem_addr_o <= mem_addr_o + 32'd4;
          count_o    <= cnt_next;
        end
        if (session_end) begin
          state  <= S_DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end else begin
          state      <= S_ACCEPT;
          in_ready_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ucsbece154a_imem_loader.sv
// Bench for the instruction loader: directed encodings, rejection rules, depth limit,
// mid-write reset and randomized sessions against an arithmetic encoding model.
module tb_ucsbece154a_imem_loader;

  logic        clk;
  logic        reset;
  logic        start, in_valid, in_ready;
  logic [2:0]  kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] imm;
  logic        last;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic        busy, done, err;
  logic [6:0]  count;

  logic        start4, valid4, ready4, we4, busy4, done4, err4;
  logic [31:0] addr4, wd4;
  logic [2:0]  count4;

  int total = 0;
  int bad   = 0;
  int exp_count;
  int exp_err;
  logic [31:0] exp_addr;

`ifdef UCSBECE154A_LOADER_VERIFY_EN
  logic [31:0] mem_rd;
  logic        verr, verr4;
  logic        zero_rd;
  logic [31:0] imem [0:63];
  always @(posedge clk) if (mem_we) imem[mem_addr[7:2]] <= mem_wd;
  assign mem_rd = zero_rd ? 32'h0 : imem[mem_addr[7:2]];
`endif

  ucsbece154a_imem_loader dut (
    .clk(clk), .reset(reset), .start_i(start), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .kind_i(kind), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3),
    .funct7b5_i(funct7b5), .imm_i(imm), .last_i(last), .mem_we_o(mem_we),
    .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .busy_o(busy), .done_o(done),
    .err_o(err), .count_o(count)
`ifdef UCSBECE154A_LOADER_VERIFY_EN
    , .mem_rd_i(mem_rd), .verr_o(verr)
`endif
  );

  ucsbece154a_imem_loader #(.BASE_ADDR(32'h0), .DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .start_i(start4), .in_valid_i(valid4), .in_ready_o(ready4),
    .kind_i(kind), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3),
    .funct7b5_i(funct7b5), .imm_i(imm), .last_i(last), .mem_we_o(we4),
    .mem_addr_o(addr4), .mem_wd_o(wd4), .busy_o(busy4), .done_o(done4),
    .err_o(err4), .count_o(count4)
`ifdef UCSBECE154A_LOADER_VERIFY_EN
    , .mem_rd_i(32'h0), .verr_o(verr4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: legality from signed ranges, encoding from shifts and masks.
  function automatic bit m_legal(input bit [2:0] k, input int v);
    case (k)
      0, 1, 4: return (v >= -2048) && (v <= 2047);
      2:       return 1'b1;
      3:       return (v >= -4096) && (v <= 4094) && (v % 2 == 0);
      5:       return (v >= -(1 << 20)) && (v <= (1 << 20) - 2) && (v % 2 == 0);
      6:       return (v & 'hFFF) == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [31:0] m_word(input bit [2:0] k, input bit [31:0] d, input bit [31:0] s1,
                                       input bit [31:0] s2, input bit [31:0] f3,
                                       input bit [31:0] f7, input bit [31:0] u);
    case (k)
      0: return ((u & 'hFFF) << 20) | (s1 << 15) | (2 << 12) | (d << 7) | 'h03;
      1: return (((u >> 5) & 'h7F) << 25) | (s2 << 20) | (s1 << 15) | (2 << 12)
                | ((u & 'h1F) << 7) | 'h23;
      2: return (f7 << 30) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 'h33;
      3: return (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (s2 << 20) | (s1 << 15)
                | (((u >> 1) & 'hF) << 8) | (((u >> 11) & 1) << 7) | 'h63;
      4: return ((u & 'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | 'h13;
      5: return (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20)
                | (((u >> 12) & 'hFF) << 12) | (d << 7) | 'h6F;
      default: return (u & 'hFFFFF000) | (d << 7) | 'h37;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_addr  = 32'h0;
    exp_count = 0;
  endtask

  // Entered and left at a falling edge; returns two slots after the handshake.
  task automatic send(input bit [2:0] k, input bit [4:0] d, input bit [4:0] s1, input bit [4:0] s2,
                      input bit [2:0] f3, input bit f7, input int v, input bit lst);
    int n;
    bit ok;
    kind = k; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7b5 = f7;
    imm = v; last = lst; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("handshake_wait", 32'(n < 20), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    ok = m_legal(k, v);
    check("we_strobe", 32'(mem_we), 32'(ok));
    if (ok) begin
      check("wdata", mem_wd, m_word(k, d, s1, s2, f3, f7, v));
      check("waddr", mem_addr, exp_addr);
      exp_addr  = exp_addr + 32'd4;
      exp_count = exp_count + 1;
    end else begin
      exp_err = 1;
    end
    check("err_sticky", 32'(err), 32'(exp_err));
    @(negedge clk);
    check("we_one_cycle", 32'(mem_we), 32'd0);
`ifdef UCSBECE154A_LOADER_VERIFY_EN
    if (ok) @(negedge clk);
`endif
    check("count", 32'(count), 32'(exp_count));
  endtask

  initial begin
    int wr4;
    int nb;
    bit [2:0] rk;
    int rv;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; start4 = 1'b0; valid4 = 1'b0;
    kind = 3'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7b5 = 1'b0;
    imm = 32'h0; last = 1'b0; exp_err = 0; exp_addr = 32'h0; exp_count = 0;
`ifdef UCSBECE154A_LOADER_VERIFY_EN
    zero_rd = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wd", mem_wd, 32'h0);
    check("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("idle_no_ready", 32'(in_ready), 32'd0);

    // Session 1: the reference encodings, addresses consecutive from the base.
    do_start();
    check("start_busy", 32'(busy), 32'd1);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 0, 1'b0);
    check("add_word", mem_wd, 32'h002081B3);
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 0, 1'b0);
    check("sub_word", mem_wd, 32'h402081B3);
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'd7, 1'b0, 8, 1'b0);
    check("lw_word", mem_wd, 32'h00812283);
    send(3'd1, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 12, 1'b0);
    check("sw_word", mem_wd, 32'h00512623);
    send(3'd6, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b1);
    check("lui_word", mem_wd, 32'h123452B7);
    check("s1_done", {30'd0, done, busy}, 32'd2);
    check("s1_ready_low", 32'(in_ready), 32'd0);
    check("s1_count5", 32'(count), 32'd5);
    check("s1_next_addr", mem_addr, 32'd20);

    // Session 2: branch encoding and the rejection rules.
    do_start();
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd5, 1'b0, -8, 1'b0);
    check("beq_word", mem_wd, 32'hFE208CE3);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 3, 1'b0);
    send(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 2048, 1'b0);
    send(3'd0, 5'd4, 5'd4, 5'd0, 3'd0, 1'b0, 2048, 1'b0);
    send(3'd4, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, -1, 1'b0);
    send(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 0, 1'b1);
    check("illegal_last_done", 32'(done), 32'd1);
    check("s2_count", 32'(count), 32'd3);

    // A new session keeps err; start while accepting is ignored.
    do_start();
    check("err_survives_start", 32'(err), 32'd1);
    check("start_clears_done", 32'(done), 32'd0);
    send(3'd4, 5'd9, 5'd8, 5'd0, 3'd6, 1'b0, 100, 1'b0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_ignored_addr", mem_addr, 32'd4);
    check("start_ignored_count", 32'(count), 32'd1);
    send(3'd2, 5'd10, 5'd11, 5'd12, 3'd4, 1'b0, 0, 1'b1);

    // Randomized sessions against the model.
    for (int s = 0; s < 8; s++) begin
      do_start();
      nb = $urandom_range(1, 8);
      for (int i = 0; i < nb; i++) begin
        rk = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: rv = int'($urandom_range(0, 4400)) - 2200;
          1: rv = int'($urandom);
          2: rv = int'($urandom_range(0, 1 << 22)) - (1 << 21);
          default: rv = int'($urandom & 32'hFFFFF000);
        endcase
        send(rk, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), rv,
             i == nb - 1);
      end
      check("rand_done", 32'(done), 32'd1);
    end

    // DEPTH=4 instance: a held-valid stream stops after four words.
    kind = 3'd2; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; funct3 = 3'd0; funct7b5 = 1'b0;
    imm = 32'h0; last = 1'b0;
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    valid4 = 1'b1;
    wr4 = 0;
    repeat (24) begin
      @(negedge clk);
      if (we4) wr4++;
    end
    check("d4_writes", 32'(wr4), 32'd4);
    check("d4_done", 32'(done4), 32'd1);
    check("d4_ready_low", 32'(ready4), 32'd0);
    check("d4_count", 32'(count4), 32'd4);
    check("d4_addr", addr4, 32'd16);
    check("d4_word", wd4, m_word(3'd2, 3, 1, 2, 0, 0, 0));
    valid4 = 1'b0;

    // Reset in the write cycle drops the strobe immediately.
    do_start();
    kind = 3'd0; rd = 5'd1; rs1 = 5'd2; imm = 32'd4; last = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_reset_we", 32'(mem_we), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_reset_we", 32'(mem_we), 32'd0);
    check("mid_reset_state", {mem_addr[7:0], 19'd0, in_ready, busy, done, err, count},
          32'd0);
    check("mid_reset_wd", mem_wd, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_err = 0;
    @(negedge clk);

`ifdef UCSBECE154A_LOADER_VERIFY_EN
    do_start();
    zero_rd = 1'b1;
    send(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 0, 1'b1);
    check("verr_on_mismatch", 32'(verr), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    zero_rd = 1'b0;
    @(negedge clk);
    do_start();
    send(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 8, 1'b1);
    check("verr_clean", 32'(verr), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
